// File: rtl/fft_frame_sched.sv
// rtl/fft_frame_sched.sv - two-requester frame scheduler in front of a shared fft_ifft core
//
// Ports:
//   i_clk, i_rst                      clock, synchronous active-high reset
//   i_fwd_req/valid/xI/xQ             forward (F) requester request and sample stream
//   o_fwd_gnt, o_fwd_ready            F owns the core / F sample accepted this cycle
//   i_inv_req/valid/xI/xQ             inverse (V) requester request and sample stream
//   o_inv_gnt, o_inv_ready            V owns the core / V sample accepted this cycle
//   o_core_valid/xI/xQ/inverse        shared core input drive
//   i_core_ready/start/valid/yI/yQ    shared core status and result stream
//   o_fwd_ovalid, o_inv_ovalid        result destination strobes (registered)
//   o_yI, o_yQ                        result data, core data delayed one cycle
//   o_busy                            scheduler not idle or results still owed

module fft_frame_sched_tag_fifo (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_push,
  input  logic i_push_tag,
  input  logic i_pop,
  output logic o_head,
  output logic o_empty,
  output logic o_full
);
  // Two-entry shift queue: ent0 is always the head.
  logic       ent0_q, ent0_d;
  logic       ent1_q, ent1_d;
  logic [1:0] cnt_q, cnt_d;
  logic       do_push, do_pop;

  assign o_head  = ent0_q;
  assign o_empty = (cnt_q == 2'd0);
  assign o_full  = (cnt_q == 2'd2);
  assign do_pop  = i_pop & ~o_empty;
  assign do_push = i_push & (~o_full | do_pop);

  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    cnt_d  = cnt_q;
    if (do_push && do_pop) begin
      if (cnt_q == 2'd1) begin
        ent0_d = i_push_tag;
      end else begin
        ent0_d = ent1_q;
        ent1_d = i_push_tag;
      end
    end else if (do_push) begin
      if (cnt_q == 2'd0) ent0_d = i_push_tag;
      else               ent1_d = i_push_tag;
      cnt_d = cnt_q + 2'd1;
    end else if (do_pop) begin
      ent0_d = ent1_q;
      cnt_d  = cnt_q - 2'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ent0_q <= 1'b0;
      ent1_q <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

module fft_frame_sched #(
  parameter int NFFT = 32,
  parameter int LOGN = 5,
  parameter int NB   = 17
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_fwd_req,
  input  logic                 i_fwd_valid,
  input  logic signed [NB-1:0] i_fwd_xI,
  input  logic signed [NB-1:0] i_fwd_xQ,
  output logic                 o_fwd_gnt,
  output logic                 o_fwd_ready,
  input  logic                 i_inv_req,
  input  logic                 i_inv_valid,
  input  logic signed [NB-1:0] i_inv_xI,
  input  logic signed [NB-1:0] i_inv_xQ,
  output logic                 o_inv_gnt,
  output logic                 o_inv_ready,
  output logic                 o_core_valid,
  output logic signed [NB-1:0] o_core_xI,
  output logic signed [NB-1:0] o_core_xQ,
  output logic                 o_core_inverse,
  input  logic                 i_core_ready,
  input  logic                 i_core_start,
  input  logic                 i_core_valid,
  input  logic signed [NB-1:0] i_core_yI,
  input  logic signed [NB-1:0] i_core_yQ,
  output logic                 o_fwd_ovalid,
  output logic                 o_inv_ovalid,
  output logic signed [NB-1:0] o_yI,
  output logic signed [NB-1:0] o_yQ,
  output logic                 o_busy
);
  localparam logic [LOGN:0] CNT_LAST = (LOGN+1)'(NFFT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD_F, ST_LOAD_V} state_t;

  state_t           state_q, state_d;
  logic [LOGN:0]    in_cnt_q, in_cnt_d;
  logic [LOGN:0]    out_cnt_q, out_cnt_d;
  logic             rr_inv_q, rr_inv_d;   // 1: V wins the next tie
  logic             err_sync_q, err_sync_d;
  logic             fwd_ov_q, fwd_ov_d;
  logic             inv_ov_q, inv_ov_d;
  logic [NB-1:0]    yi_q, yi_d;
  logic [NB-1:0]    yq_q, yq_d;

  logic gnt_f, gnt_v, xfer, in_last, route, out_last;
  logic fifo_head, fifo_empty, fifo_full;

  assign gnt_f = (state_q == ST_LOAD_F);
  assign gnt_v = (state_q == ST_LOAD_V);

  assign o_fwd_gnt      = gnt_f;
  assign o_inv_gnt      = gnt_v;
  assign o_fwd_ready    = gnt_f & i_core_ready;
  assign o_inv_ready    = gnt_v & i_core_ready;
  assign xfer           = ((gnt_f & i_fwd_valid) | (gnt_v & i_inv_valid)) & i_core_ready;
  assign o_core_valid   = xfer;
  assign o_core_xI      = gnt_f ? i_fwd_xI : (gnt_v ? i_inv_xI : '0);
  assign o_core_xQ      = gnt_f ? i_fwd_xQ : (gnt_v ? i_inv_xQ : '0);
  assign o_core_inverse = gnt_v;

  assign in_last  = xfer & (in_cnt_q == CNT_LAST);
  // Results with no frame owed are dropped; only owed results are routed.
  assign route    = i_core_valid & ~fifo_empty;
  assign out_last = route & (out_cnt_q == CNT_LAST);

  assign o_fwd_ovalid = fwd_ov_q;
  assign o_inv_ovalid = inv_ov_q;
  assign o_yI         = yi_q;
  assign o_yQ         = yq_q;
  assign o_busy       = (state_q != ST_IDLE) | ~fifo_empty;

  fft_frame_sched_tag_fifo u_tag_fifo (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_push     (in_last),
    .i_push_tag (gnt_v),
    .i_pop      (out_last),
    .o_head     (fifo_head),
    .o_empty    (fifo_empty),
    .o_full     (fifo_full)
  );

  always_comb begin
    state_d    = state_q;
    in_cnt_d   = in_cnt_q;
    out_cnt_d  = out_cnt_q;
    rr_inv_d   = rr_inv_q;
    err_sync_d = err_sync_q;

    case (state_q)
      ST_IDLE: begin
        // A full tag FIFO means two frames are still owed; hold off new grants.
        if (!fifo_full) begin
          if (i_fwd_req && (!i_inv_req || !rr_inv_q)) begin
            state_d  = ST_LOAD_F;
            rr_inv_d = 1'b1;
          end else if (i_inv_req) begin
            state_d  = ST_LOAD_V;
            rr_inv_d = 1'b0;
          end
        end
      end
      ST_LOAD_F, ST_LOAD_V: begin
        if (in_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (in_last)   in_cnt_d = '0;
    else if (xfer) in_cnt_d = in_cnt_q + 1'b1;

    if (out_last)   out_cnt_d = '0;
    else if (route) out_cnt_d = out_cnt_q + 1'b1;

    if ((i_core_start && out_cnt_q != '0) || (i_core_valid && fifo_empty))
      err_sync_d = 1'b1;

    fwd_ov_d = route & ~fifo_head;
    inv_ov_d = route & fifo_head;
    yi_d     = i_core_yI;
    yq_d     = i_core_yQ;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      in_cnt_q   <= '0;
      out_cnt_q  <= '0;
      rr_inv_q   <= 1'b0;
      err_sync_q <= 1'b0;
      fwd_ov_q   <= 1'b0;
      inv_ov_q   <= 1'b0;
      yi_q       <= '0;
      yq_q       <= '0;
    end else begin
      state_q    <= state_d;
      in_cnt_q   <= in_cnt_d;
      out_cnt_q  <= out_cnt_d;
      rr_inv_q   <= rr_inv_d;
      err_sync_q <= err_sync_d;
      fwd_ov_q   <= fwd_ov_d;
      inv_ov_q   <= inv_ov_d;
      yi_q       <= yi_d;
      yq_q       <= yq_d;
    end
  end
endmodule

// File: doc/fft_frame_sched.md
FFT_FRAME_SCHED -- requirements
Module: fft_frame_sched

Interface
REQ-001 Parameter NFFT, default 32, the frame length in complex samples.
REQ-002 Parameter LOGN, default 5, log2(NFFT), used as the counter width.
REQ-003 Parameter NB, default 17, the sample width per I/Q component, signed.
REQ-004 i_clk  in  1  the single clock, rising edge.
REQ-005 i_rst  in  1  reset, synchronous, active-high.
REQ-006 i_fwd_req  in  1  requester F has a forward-FFT frame pending.
REQ-007 i_fwd_valid, i_fwd_xI, i_fwd_xQ  in  1,NB,NB  requester F sample stream.
REQ-008 o_fwd_gnt, o_fwd_ready  out  1,1  F owns the core; F sample is accepted this cycle.
REQ-009 i_inv_req, i_inv_valid, i_inv_xI, i_inv_xQ  in  1,1,NB,NB  requester V (IFFT) request and stream.
REQ-010 o_inv_gnt, o_inv_ready  out  1,1  V grant and V sample accept.
REQ-011 o_core_valid, o_core_xI, o_core_xQ, o_core_inverse  out  1,NB,NB,1  drive the shared fft_ifft core inputs.
REQ-012 i_core_ready, i_core_start, i_core_valid, i_core_yI, i_core_yQ  in  1,1,1,NB,NB  core o_in_ready, o_start, o_valid, o_yI, o_yQ.
REQ-013 o_fwd_ovalid, o_inv_ovalid, o_yI, o_yQ  out  1,1,NB,NB  routed result stream; data is shared, the valids select the destination.
REQ-014 o_busy  out  1  high in any state other than IDLE, or while the tag FIFO is non-empty.

Function
REQ-015 Input FSM states: IDLE, LOAD_F, LOAD_V.
- IDLE to LOAD_x on grant.
- LOAD_x to IDLE after NFFT accepted samples.
REQ-016 Grant condition: in IDLE, at least one request is high and the tag FIFO is not full.
- One request high: that requester wins.
- Both high: round-robin, the requester not granted last wins.
- After reset, F has priority.
REQ-017 o_fwd_gnt is high only in LOAD_F; o_inv_gnt is high only in LOAD_V.
REQ-018 Grant is a frame lock: the requester holds the core for exactly NFFT accepted samples; requests are ignored until the FSM returns to IDLE.
REQ-019 Ready and data path:
- o_x_ready = gnt_x AND i_core_ready, combinational.
- o_core_valid = gnt_x AND i_x_valid AND i_core_ready.
- o_core_xI/xQ = the granted requester's data; 0 when no grant.
REQ-020 o_core_inverse is 1 in LOAD_V and 0 otherwise. It is constant across a frame.
REQ-021 Input sample counter (LOGN+1 bits):
- Increments on each o_core_valid.
- At NFFT-1 with a transfer: push the tag (1 = inverse) into the tag FIFO, clear the counter, go to IDLE.
- A new grant is possible the following cycle.
REQ-022 Tag FIFO: depth 2, 1-bit entries.
- Push and pop in the same cycle are both performed and the count is unchanged.
- Push when full cannot occur, because grant is blocked per REQ-016.
REQ-023 Output routing:
- If the FIFO is non-empty and i_core_valid is high: head tag 0 asserts o_fwd_ovalid, head tag 1 asserts o_inv_ovalid.
- Registered with 1-cycle latency: o_yI/o_yQ carry the core data of the previous cycle.
REQ-024 Output counter (LOGN+1 bits):
- Counts routed samples.
- On the NFFT-th sample, pop the FIFO and clear the counter.
- i_core_start is used only as a check: a start seen with the output counter at a nonzero value sets the sticky internal flag err_sync.
REQ-025 If i_core_valid arrives while the FIFO is empty, the sample is dropped, no ovalid is asserted, and err_sync is set.
REQ-026 A requester deasserting valid mid-frame stalls the frame. There is no timeout and the grant is held.

Reset
REQ-027 On i_rst:
- FSM goes to IDLE; both counters, the FIFO, err_sync and the round-robin pointer clear.
- All outputs go to 0, including o_yI and o_yQ.
REQ-028 Reset asserted mid-frame abandons the partial frame and the pending tags. Core outputs after reset are dropped per REQ-025.
REQ-029 Outputs become active on the first edge after i_rst falls.

Verification
REQ-030 F only: one 32-sample frame with ramp I=n, Q=-n, core always ready -> o_core_inverse=0 throughout, 32 core transfers, then 32 o_fwd_ovalid pulses and 0 o_inv_ovalid pulses.
REQ-031 Both requests high in the same cycle after reset -> F is granted first, then V. Next simultaneous request -> V is granted first, i.e. grants alternate.
REQ-032 Closed loop with the real fft_ifft core: F frame x (random Q10, values in [-256,255]); feed its routed output into V -> the V output equals x within 1 LSB per I and Q sample.
REQ-033 Backpressure: i_core_ready toggles 1/0 each cycle and i_fwd_valid drops for 3 cycles at sample 10 -> exactly 32 transfers, no duplicated or skipped samples, o_fwd_gnt held continuously.
REQ-034 Two frames queued (FIFO full) before any output -> a third i_fwd_req is not granted until 32 outputs have popped the FIFO. Output tags are routed in push order.
REQ-035 i_rst pulsed at input sample 15 -> all outputs are 0 the next cycle, FIFO empty, and a fresh frame completes normally.
